// File: rtl/fp_int_wb_buffer_if.sv
// Handshake bundle between the FP integer-destination units, the result buffer
// and the integer register-file write port.
interface fp_int_wb_buffer_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [4:0]  in_rd;
    logic        in_w32;
    logic        wb_valid;
    logic        wb_ready;
    logic [63:0] wb_data;
    logic [4:0]  wb_rd;

    // Buffer side
    modport slave (
        input  in_valid, in_data, in_rd, in_w32, wb_ready,
        output in_ready, wb_valid, wb_data, wb_rd
    );

    // Producer / write-port side
    modport master (
        output in_valid, in_data, in_rd, in_w32, wb_ready,
        input  in_ready, wb_valid, wb_data, wb_rd
    );
endinterface

// File: rtl/fp_int_wb_buffer.sv
// In-order result FIFO from FP integer-destination units to the integer write port.
// Optional macro FP_WB_DROP_X0_EN: accept rd=0 results without storing them.
module fp_int_wb_buffer #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    fp_int_wb_buffer_if.slave     bus,
    output logic [CW-1:0]         count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [63:0] data;
        logic [4:0]  rd;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic            wr;
    logic [63:0]     ext_data;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // in_ready is also held low while reset is asserted
    assign bus.in_ready = en & rst_n & ~full;
    assign bus.wb_valid = en & ~empty;

    assign push = bus.in_valid & bus.in_ready;
    assign pop  = bus.wb_valid & bus.wb_ready;

`ifdef FP_WB_DROP_X0_EN
    assign wr = push & (bus.in_rd != 5'd0);
`else
    assign wr = push;
`endif

    // RV64F: W-form results are sign-extended from bit 31 before storage
    assign ext_data = bus.in_w32 ? {{32{bus.in_data[31]}}, bus.in_data[31:0]}
                                 : bus.in_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr)  wptr <= wptr + AW'(1);
            if (pop) rptr <= rptr + AW'(1);
            case ({wr, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (wr) mem[wptr] <= '{data: ext_data, rd: bus.in_rd};
    end

    assign bus.wb_data = mem[rptr].data;
    assign bus.wb_rd   = mem[rptr].rd;
endmodule

// File: tb/tb_fp_int_wb_buffer.sv
// Directed bench for fp_int_wb_buffer: extension, fill/full, wrap order, stall, reset.
module tb_fp_int_wb_buffer;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst_n;
    logic          en;
    logic [CW-1:0] count;
    int            n_vec;
    int            n_err;

    fp_int_wb_buffer_if bus ();

    fp_int_wb_buffer #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .bus   (bus),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] d, input logic [4:0] rd, input logic w);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_rd    = rd;
        bus.in_w32   = w;
    endtask

    initial begin
        int next_push;
        int exp_pop;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        en    = 1'b1;
        bus.wb_ready = 1'b0;
        drive(1'b0, 64'h0, 5'd0, 1'b0);
        #3;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Negative W result sign-extends
        drive(1'b1, 64'h0000_0000_C169_6042, 5'd5, 1'b1);
        step();
        drive(1'b0, 64'h0, 5'd0, 1'b0);
        chk("w_neg_valid", 64'(bus.wb_valid), 64'd1);
        chk("w_neg_data", bus.wb_data, 64'hFFFF_FFFF_C169_6042);
        chk("w_neg_rd", 64'(bus.wb_rd), 64'd5);
        chk("w_neg_count", 64'(count), 64'd1);
        bus.wb_ready = 1'b1;
        step();
        bus.wb_ready = 1'b0;
        chk("pop1_count", 64'(count), 64'd0);
        chk("pop1_valid", 64'(bus.wb_valid), 64'd0);

        // Positive W result, then simultaneous pop + 64-bit passthrough push
        drive(1'b1, 64'hDEAD_BEEF_423D_0625, 5'd7, 1'b1);
        step();
        chk("w_pos_data", bus.wb_data, 64'h0000_0000_423D_0625);
        chk("w_pos_rd", 64'(bus.wb_rd), 64'd7);
        drive(1'b1, 64'h8000_0000_0000_0001, 5'd9, 1'b0);
        bus.wb_ready = 1'b1;
        step();
        drive(1'b0, 64'h0, 5'd0, 1'b0);
        chk("pushpop_count", 64'(count), 64'd1);
        chk("d64_data", bus.wb_data, 64'h8000_0000_0000_0001);
        chk("d64_rd", 64'(bus.wb_rd), 64'd9);
        step();
        bus.wb_ready = 1'b0;
        chk("drain2_count", 64'(count), 64'd0);

        // Fill to DEPTH with the write port blocked
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 64'(100 + i), 5'(11 + i), 1'b0);
            step();
        end
        chk("full_count", 64'(count), 64'd4);
        chk("full_in_ready", 64'(bus.in_ready), 64'd0);
        drive(1'b1, 64'd200, 5'd15, 1'b0);
        step();
        chk("held_count", 64'(count), 64'd4);
        chk("held_head", 64'(bus.wb_rd), 64'd11);
        bus.wb_ready = 1'b1;
        step();
        bus.wb_ready = 1'b0;
        drive(1'b0, 64'h0, 5'd0, 1'b0);
        chk("full_pop_count", 64'(count), 64'd3);
        chk("full_pop_ready", 64'(bus.in_ready), 64'd1);
        chk("full_pop_head", 64'(bus.wb_rd), 64'd12);
        chk("full_pop_data", bus.wb_data, 64'd101);
        bus.wb_ready = 1'b1;
        step();
        step();
        step();
        bus.wb_ready = 1'b0;
        chk("fill_drained", 64'(count), 64'd0);

        // Stream 10 entries with toggling wb_ready; pointers wrap
        next_push = 1;
        exp_pop   = 1;
        for (int cyc = 0; cyc < 200 && exp_pop <= 10; cyc++) begin
            logic pf;
            logic rf;
            drive(next_push <= 10, 64'(next_push * 3), 5'(next_push), 1'b0);
            bus.wb_ready = cyc[0];
            #1;
            pf = bus.in_valid & bus.in_ready;
            rf = bus.wb_valid & bus.wb_ready;
            if (rf) begin
                chk("order_rd", 64'(bus.wb_rd), 64'(exp_pop));
                chk("order_data", bus.wb_data, 64'(exp_pop * 3));
                exp_pop++;
            end
            step();
            if (pf) next_push++;
        end
        drive(1'b0, 64'h0, 5'd0, 1'b0);
        bus.wb_ready = 1'b0;
        chk("stream_all_popped", 64'(exp_pop), 64'd11);
        chk("stream_all_pushed", 64'(next_push), 64'd11);
        chk("stream_empty", 64'(count), 64'd0);

        // Stall with two entries held
        drive(1'b1, 64'd20, 5'd20, 1'b0);
        step();
        drive(1'b1, 64'd21, 5'd21, 1'b0);
        step();
        chk("stall_pre_count", 64'(count), 64'd2);
        en = 1'b0;
        bus.wb_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
            chk("stall_wb_valid", 64'(bus.wb_valid), 64'd0);
            chk("stall_count", 64'(count), 64'd2);
        end
        drive(1'b0, 64'h0, 5'd0, 1'b0);
        bus.wb_ready = 1'b0;
        en = 1'b1;
        #1;
        chk("resume_valid", 64'(bus.wb_valid), 64'd1);
        chk("resume_head", 64'(bus.wb_rd), 64'd20);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_count", 64'(count), 64'd0);
        chk("async_rst_valid", 64'(bus.wb_valid), 64'd0);
        chk("async_rst_ready", 64'(bus.in_ready), 64'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("rerelease_ready", 64'(bus.in_ready), 64'd1);

        // Destination x0
        drive(1'b1, 64'h55, 5'd0, 1'b0);
        #1;
        chk("x0_in_ready", 64'(bus.in_ready), 64'd1);
        step();
        drive(1'b0, 64'h0, 5'd0, 1'b0);
`ifdef FP_WB_DROP_X0_EN
        chk("x0_drop_count", 64'(count), 64'd0);
        chk("x0_drop_valid", 64'(bus.wb_valid), 64'd0);
`else
        chk("x0_keep_count", 64'(count), 64'd1);
        chk("x0_keep_rd", 64'(bus.wb_rd), 64'd0);
        chk("x0_keep_data", bus.wb_data, 64'h55);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fp_int_wb_buffer.md
# fp_int_wb_buffer

Result buffer between the floating-point ALU's integer-destination units (FMV.X.W, FCLASS.S, FEQ/FLT/FLE.S, FCVT.W[U].S) and the integer register-file write port. It accepts one 64-bit result per cycle through a valid/ready handshake and sign-extends 32-bit (W-form) results to XLEN=64 per RV64F. Results are held in an in-order FIFO and presented to the write port through a second valid/ready handshake. This decouples FP-unit completion from integer write-port availability.

## Interface
- DEPTH, 4, FIFO entries; power of two, 2..16
- CW, $clog2(DEPTH+1), width of occupancy count

- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous reset, active-low
- EN  in  1  global stage enable; low = stall both sides
- in_valid  in  1  producer has a result
- in_ready  out  1  buffer accepts this cycle
- in_data  in  64  raw result; only [31:0] meaningful when in_w32=1
- in_rd  in  5  integer destination register
- in_w32  in  1  1 = 32-bit result, sign-extend bit 31
- wb_valid  out  1  head entry available
- wb_ready  in  1  write port consumes head
- wb_data  out  64  head result, already extended
- wb_rd  out  5  head destination
- count  out  CW  current occupancy

## Operation
- Push when in_valid & in_ready. Stored data = in_w32 ? {{32{in_data[31]}}, in_data[31:0]} : in_data. Extension is done before storage.
- Pop when wb_valid & wb_ready. The head advances in order.
- in_ready = EN & (count != DEPTH). There is no same-cycle pass-through when full: a pop in a full cycle does not free space until the next cycle.
- wb_valid = EN & (count != 0). wb_data and wb_rd are driven combinationally from the head entry. Their value is don't-care when wb_valid=0.
- Write and read pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- count update:
  - +1 on push only
  - -1 on pop only
  - unchanged on simultaneous push and pop, or on neither
- EN=0 freezes all pointers, count, and storage. Stored entries are preserved.

## Timing
- Reset (RST low, asynchronous): pointers=0, count=0, in_ready=0, wb_valid=0. Storage contents are not reset. Consequently wb_data=0 and wb_rd=0 are not guaranteed.
- Reset mid-operation discards all entries immediately. After RST rises, in_ready=1 in the first cycle with EN=1.
- Latency: a result pushed at edge N is visible with wb_valid=1 after edge N. Minimum in-to-out latency is 1 cycle. There is no bypass when the buffer is empty.
- Throughput: 1 push and 1 pop per cycle when 0 < count < DEPTH.
- Full (count=DEPTH): in_ready=0. A producer holding in_valid must keep in_data, in_rd, and in_w32 stable.
- Empty: a pop is impossible because wb_valid=0.

## Configuration
- FP_WB_DROP_X0_EN
  - Defined: a push with in_rd=0 completes the handshake (in_ready as normal) but is not written into the FIFO. count and pointers are unchanged.
  - Undefined: rd=0 results are buffered and written back like any other entry; the register file discards them.

## Test plan
- Reset then single W push: EN=1, in_valid=1, in_w32=1, in_data=64'h0000_0000_C169_6042 (-14.586f), in_rd=5 -> the next cycle shows wb_valid=1, wb_data=64'hFFFF_FFFF_C169_6042, wb_rd=5, count=1.
- Positive W result and 64-bit passthrough:
  - 32'h423D_0625 with w32=1 -> wb_data=64'h0000_0000_423D_0625.
  - 64'h8000_0000_0000_0001 with w32=0 -> wb_data unchanged.
- Fill with wb_ready=0: push DEPTH=4 entries -> count=4 and in_ready=0. A fifth in_valid is held off. Then assert wb_ready=1 for 1 cycle together with in_valid -> the pop occurs and the push does not. Next cycle count=3 and in_ready=1.
- Wrap and order: stream 10 pushes (rd=1..10) with wb_ready toggling 1/0 -> pops occur in rd order 1..10 with no loss or duplication. Pointers wrap at least twice.
- Stall and reset: with count=2, drive EN=0 for 3 cycles -> in_ready=0, wb_valid=0, and count stays 2. Re-enable -> the same head entry appears. Then assert RST low asynchronously mid-cycle -> count=0 and wb_valid=0 immediately.
- Macro:
  - With FP_WB_DROP_X0_EN defined, push rd=0 -> the handshake completes, count stays 0, and wb_valid stays 0.
  - With the macro undefined -> count=1 and wb_rd=0.
